// File: rtl/fetch_unpack_pkg.sv
// Shared widths, slot-mask encodings and the value presented for a faulted fetch.
package fetch_unpack_pkg;

   localparam int BUNDLE_W = 64;
   localparam int INSTR_W  = 32;

   // Slot-valid mask of the buffered bundle: bit0 = slot0 (low word), bit1 = slot1 (high word).
   typedef enum logic [1:0] {
      MASK_EMPTY   = 2'b00,
      MASK_LO_ONLY = 2'b01,
      MASK_HI_ONLY = 2'b10,
      MASK_BOTH    = 2'b11
   } slot_mask_e;

   localparam logic [INSTR_W-1:0] FAULT_INSTR = 32'h0;

endpackage

// File: rtl/fetch_unpack.sv
// Splits an 8-byte fetch bundle into two 32-bit instructions, one per cycle.
// A single registered bundle is held; its slot-valid mask drives the sequencing.
//
//   mask    | meaning
//   --------+----------------------------------------------
//   EMPTY   | nothing buffered, ready for a new bundle
//   BOTH    | slot0 and slot1 pending, slot0 presented
//   HI_ONLY | only slot1 pending (consumed slot0 or entered at +4)
//   LO_ONLY | only slot0 pending (predicted taken or faulted)
import fetch_unpack_pkg::*;

module fetch_unpack #(
   parameter bit SUPPORT_PRED = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_i,

   input  logic                fetch_valid_i,
   input  logic [BUNDLE_W-1:0] fetch_instr_i,
   input  logic [31:0]         fetch_pc_i,
   input  logic [1:0]          fetch_pred_branch_i,
   input  logic                fetch_fault_fetch_i,
   input  logic                fetch_fault_page_i,
   output logic                fetch_accept_o,

   input  logic                branch_request_i,
   input  logic [31:0]         branch_pc_i,

   output logic                out_valid_o,
   output logic [INSTR_W-1:0]  out_instr_o,
   output logic [31:0]         out_pc_o,
   output logic                out_pred_branch_o,
   output logic                out_fault_fetch_o,
   output logic                out_fault_page_o,
   input  logic                out_accept_i
);

   logic [BUNDLE_W-1:0] data_q, data_d;
   logic [31:3]         pc_q, pc_d;
   logic [1:0]          pred_q, pred_d;
   logic                fault_fetch_q, fault_fetch_d;
   logic                fault_page_q, fault_page_d;
   slot_mask_e          mask_q, mask_d;
   logic                skip_q, skip_d;

   logic                slot_sel;
   logic                one_valid;
   logic                load;
   logic [1:0]          load_mask;

   // Only the bundle-aligned part of the fetch PC and the slot bit of the redirect matter.
   logic                unused_pc_bits;
   assign unused_pc_bits = ^{fetch_pc_i[2:0], branch_pc_i[31:3], branch_pc_i[1:0]};

   // Presentation side: lowest pending slot drives the outputs straight from registers.
   always_comb begin
      slot_sel          = (mask_q == MASK_HI_ONLY);
      one_valid         = (mask_q == MASK_LO_ONLY) || (mask_q == MASK_HI_ONLY);
      out_valid_o       = (mask_q != MASK_EMPTY);
      out_instr_o       = (fault_fetch_q || fault_page_q) ? FAULT_INSTR :
                          (slot_sel ? data_q[63:32] : data_q[31:0]);
      out_pc_o          = {pc_q, slot_sel, 2'b00};
      out_pred_branch_o = pred_q[slot_sel];
      out_fault_fetch_o = fault_fetch_q;
      out_fault_page_o  = fault_page_q;
      // A new bundle may enter when empty, or when the last pending slot leaves this cycle.
      fetch_accept_o    = !branch_request_i &&
                          ((mask_q == MASK_EMPTY) || (one_valid && out_valid_o && out_accept_i));
      load              = fetch_valid_i && fetch_accept_o;
   end

   // Next-state: consume, then load overrides, then redirect overrides everything.
   always_comb begin
      data_d        = data_q;
      pc_d          = pc_q;
      pred_d        = pred_q;
      fault_fetch_d = fault_fetch_q;
      fault_page_d  = fault_page_q;
      mask_d        = mask_q;
      skip_d        = skip_q;

      // Redirect into the upper word skips slot0; a taken slot0 makes slot1 dead;
      // a faulted bundle carries only its first slot.
      load_mask = skip_q ? 2'b10 : 2'b11;
      if (SUPPORT_PRED && !skip_q && fetch_pred_branch_i[0]) begin
         load_mask = 2'b01;
      end
      if (fetch_fault_fetch_i || fetch_fault_page_i) begin
         load_mask = skip_q ? 2'b10 : 2'b01;
      end

      if (out_valid_o && out_accept_i) begin
         mask_d = slot_mask_e'(mask_q & (slot_sel ? 2'b01 : 2'b10));
      end

      if (load) begin
         data_d        = fetch_instr_i;
         pc_d          = fetch_pc_i[31:3];
         pred_d        = SUPPORT_PRED ? fetch_pred_branch_i : 2'b00;
         fault_fetch_d = fetch_fault_fetch_i;
         fault_page_d  = fetch_fault_page_i;
         mask_d        = slot_mask_e'(load_mask);
         skip_d        = 1'b0;
      end

      if (branch_request_i) begin
         mask_d = MASK_EMPTY;
         skip_d = branch_pc_i[2];
      end
   end

   // Buffer registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q        <= '0;
         pc_q          <= '0;
         pred_q        <= '0;
         fault_fetch_q <= 1'b0;
         fault_page_q  <= 1'b0;
         mask_q        <= MASK_EMPTY;
         skip_q        <= 1'b0;
      end else begin
         data_q        <= data_d;
         pc_q          <= pc_d;
         pred_q        <= pred_d;
         fault_fetch_q <= fault_fetch_d;
         fault_page_q  <= fault_page_d;
         mask_q        <= mask_d;
         skip_q        <= skip_d;
      end
   end

endmodule

// File: tb/tb_fetch_unpack.sv
// Bench for fetch_unpack: expected instructions are queued when a bundle is sent
// and checked as the decode side accepts them.
module tb_fetch_unpack;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        fetch_valid_i = 1'b0;
   logic [63:0] fetch_instr_i = '0;
   logic [31:0] fetch_pc_i = '0;
   logic [1:0]  fetch_pred_branch_i = '0;
   logic        fetch_fault_fetch_i = 1'b0;
   logic        fetch_fault_page_i = 1'b0;
   logic        fetch_accept_o;
   logic        branch_request_i = 1'b0;
   logic [31:0] branch_pc_i = '0;
   logic        out_valid_o;
   logic [31:0] out_instr_o;
   logic [31:0] out_pc_o;
   logic        out_pred_branch_o;
   logic        out_fault_fetch_o;
   logic        out_fault_page_o;
   logic        out_accept_i = 1'b1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pred;
      logic        ff;
      logic        fp;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_got, mon_exp;
   int   vectors = 0;
   int   miscompares = 0;

   fetch_unpack #(.SUPPORT_PRED(1'b1)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .fetch_valid_i(fetch_valid_i), .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i),
      .fetch_pred_branch_i(fetch_pred_branch_i), .fetch_fault_fetch_i(fetch_fault_fetch_i),
      .fetch_fault_page_i(fetch_fault_page_i), .fetch_accept_o(fetch_accept_o),
      .branch_request_i(branch_request_i), .branch_pc_i(branch_pc_i),
      .out_valid_o(out_valid_o), .out_instr_o(out_instr_o), .out_pc_o(out_pc_o),
      .out_pred_branch_o(out_pred_branch_o), .out_fault_fetch_o(out_fault_fetch_o),
      .out_fault_page_o(out_fault_page_o), .out_accept_i(out_accept_i)
   );

   always #5 clk_i = ~clk_i;

   // Scoreboard: every accepted output must match the oldest queued expectation.
   always @(negedge clk_i) begin
      if (!rst_i && out_valid_o && out_accept_i) begin
         mon_got = {out_pc_o, out_instr_o, out_pred_branch_o, out_fault_fetch_o, out_fault_page_o};
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output: got pc=%h instr=%h, required no output", out_pc_o, out_instr_o);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               miscompares++;
               $display("FAIL output_entry: got pc=%h instr=%h pred=%b ff=%b fp=%b, required pc=%h instr=%h pred=%b ff=%b fp=%b",
                        mon_got.pc, mon_got.instr, mon_got.pred, mon_got.ff, mon_got.fp,
                        mon_exp.pc, mon_exp.instr, mon_exp.pred, mon_exp.ff, mon_exp.fp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_bundle(input bit align, input logic [31:0] pc, input logic [63:0] instr,
                              input logic [1:0] pred, input logic ff, input logic fp);
      int n = 0;
      if (align) begin
         @(posedge clk_i); #1;
      end
      fetch_valid_i = 1'b1; fetch_pc_i = pc; fetch_instr_i = instr;
      fetch_pred_branch_i = pred; fetch_fault_fetch_i = ff; fetch_fault_page_i = fp;
      @(negedge clk_i);
      while (!fetch_accept_o && n < 50) begin
         @(negedge clk_i); n++;
      end
      if (!fetch_accept_o) begin
         vectors++; miscompares++;
         $display("FAIL send_timeout: fetch_accept_o=%b after %0d cycles, required 1", fetch_accept_o, n);
      end
      @(posedge clk_i); #1;
      fetch_valid_i = 1'b0; fetch_fault_fetch_i = 1'b0; fetch_fault_page_i = 1'b0;
      fetch_pred_branch_i = 2'b00;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || out_valid_o) && n < 40) begin
         @(negedge clk_i); n++;
      end
      vectors++;
      if (exp_q.size() != 0 || out_valid_o) begin
         miscompares++;
         $display("FAIL %s_drain: pending=%0d out_valid=%b, required 0 and 0", name, exp_q.size(), out_valid_o);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      vectors++;
      if ({out_valid_o, out_instr_o, out_pc_o, out_pred_branch_o, out_fault_fetch_o, out_fault_page_o} !== 68'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got valid=%b instr=%h pc=%h pred=%b ff=%b fp=%b, required all 0",
                  out_valid_o, out_instr_o, out_pc_o, out_pred_branch_o, out_fault_fetch_o, out_fault_page_o);
      end
      @(posedge clk_i); #1; rst_i = 1'b0;
      @(negedge clk_i);
      vectors++;
      if (fetch_accept_o !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_accept: got %b, required 1", fetch_accept_o);
      end
   endtask

   task automatic test_dual();
      out_accept_i = 1'b1;
      exp_q.push_back({32'h1000, 32'h00100093, 1'b0, 1'b0, 1'b0});
      exp_q.push_back({32'h1004, 32'h00200093, 1'b0, 1'b0, 1'b0});
      send_bundle(1'b1, 32'h1000, {32'h00200093, 32'h00100093}, 2'b00, 1'b0, 1'b0);
      @(negedge clk_i);
      vectors++;
      if ({out_pc_o, fetch_accept_o} !== {32'h1000, 1'b0}) begin
         miscompares++;
         $display("FAIL dual_first: got pc=%h accept=%b, required pc=00001000 accept=0", out_pc_o, fetch_accept_o);
      end
      @(negedge clk_i);
      vectors++;
      if ({out_pc_o, fetch_accept_o} !== {32'h1004, 1'b1}) begin
         miscompares++;
         $display("FAIL dual_second: got pc=%h accept=%b, required pc=00001004 accept=1", out_pc_o, fetch_accept_o);
      end
      wait_drain("dual");
   endtask

   task automatic test_skip();
      @(posedge clk_i); #1;
      branch_request_i = 1'b1; branch_pc_i = 32'h2004;
      @(negedge clk_i);
      vectors++;
      if (fetch_accept_o !== 1'b0) begin
         miscompares++;
         $display("FAIL branch_blocks_accept: got %b, required 0", fetch_accept_o);
      end
      @(posedge clk_i); #1; branch_request_i = 1'b0;
      exp_q.push_back({32'h2004, 32'hAAAA0001, 1'b0, 1'b0, 1'b0});
      send_bundle(1'b0, 32'h2000, {32'hAAAA0001, 32'h55550002}, 2'b00, 1'b0, 1'b0);
      wait_drain("skip");
      repeat (3) begin
         @(negedge clk_i);
         vectors++;
         if (out_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL skip_empty_after: got out_valid=%b, required 0", out_valid_o);
         end
      end
   endtask

   task automatic test_pred();
      exp_q.push_back({32'h3000, 32'h0000A063, 1'b1, 1'b0, 1'b0});
      send_bundle(1'b1, 32'h3000, {32'hDEAD0013, 32'h0000A063}, 2'b01, 1'b0, 1'b0);
      wait_drain("pred");
      repeat (3) begin
         @(negedge clk_i);
         vectors++;
         if (out_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL pred_slot1_hidden: got out_valid=%b pc=%h, required 0", out_valid_o, out_pc_o);
         end
      end
   endtask

   task automatic test_fault();
      exp_q.push_back({32'h4000, 32'h0, 1'b0, 1'b0, 1'b1});
      send_bundle(1'b1, 32'h4000, {32'h12345678, 32'h9ABCDEF0}, 2'b00, 1'b0, 1'b1);
      wait_drain("fault_page");
      // Redirect into slot1 of a bus-faulted bundle.
      @(posedge clk_i); #1;
      branch_request_i = 1'b1; branch_pc_i = 32'h4804;
      @(posedge clk_i); #1; branch_request_i = 1'b0;
      exp_q.push_back({32'h4804, 32'h0, 1'b0, 1'b1, 1'b0});
      send_bundle(1'b0, 32'h4800, {32'h11110000, 32'h22220000}, 2'b00, 1'b1, 1'b0);
      wait_drain("fault_fetch");
   endtask

   task automatic test_stall();
      out_accept_i = 1'b0;
      send_bundle(1'b1, 32'h5000, {32'h11112222, 32'h33334444}, 2'b00, 1'b0, 1'b0);
      fetch_valid_i = 1'b1; fetch_pc_i = 32'h9000; fetch_instr_i = 64'hFFFF_FFFF_EEEE_EEEE;
      repeat (3) begin
         @(negedge clk_i);
         vectors++;
         if ({out_valid_o, out_pc_o, out_instr_o, fetch_accept_o} !== {1'b1, 32'h5000, 32'h33334444, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_hold: got valid=%b pc=%h instr=%h accept=%b, required 1 00005000 33334444 0",
                     out_valid_o, out_pc_o, out_instr_o, fetch_accept_o);
         end
      end
      @(posedge clk_i); #1;
      branch_request_i = 1'b1; branch_pc_i = 32'h6000;
      @(negedge clk_i);
      vectors++;
      if (fetch_accept_o !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_branch_accept: got %b, required 0", fetch_accept_o);
      end
      @(posedge clk_i); #1;
      branch_request_i = 1'b0; fetch_valid_i = 1'b0;
      @(negedge clk_i);
      vectors++;
      if (out_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_flush: got out_valid=%b, required 0", out_valid_o);
      end
      out_accept_i = 1'b1;
      repeat (3) @(negedge clk_i);
      wait_drain("stall");
   endtask

   task automatic test_reset_mid();
      out_accept_i = 1'b0;
      send_bundle(1'b1, 32'h7000, {32'h77770001, 32'h77770000}, 2'b00, 1'b0, 1'b0);
      @(negedge clk_i);
      vectors++;
      if (out_valid_o !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_loaded: got out_valid=%b, required 1", out_valid_o);
      end
      @(posedge clk_i); #1; rst_i = 1'b1;
      @(posedge clk_i); #1; rst_i = 1'b0;
      @(negedge clk_i);
      vectors++;
      if ({out_valid_o, fetch_accept_o, out_pc_o} !== {1'b0, 1'b1, 32'h0}) begin
         miscompares++;
         $display("FAIL rstmid_cleared: got valid=%b accept=%b pc=%h, required 0 1 00000000",
                  out_valid_o, fetch_accept_o, out_pc_o);
      end
      out_accept_i = 1'b1;
      repeat (3) @(negedge clk_i);
      wait_drain("rstmid");
   endtask

   task automatic test_back_to_back();
      out_accept_i = 1'b1;
      exp_q.push_back({32'h8000, 32'hA0000000, 1'b0, 1'b0, 1'b0});
      exp_q.push_back({32'h8004, 32'hA0000004, 1'b0, 1'b0, 1'b0});
      exp_q.push_back({32'h8008, 32'hB0000000, 1'b0, 1'b0, 1'b0});
      exp_q.push_back({32'h800C, 32'hB0000004, 1'b0, 1'b0, 1'b0});
      send_bundle(1'b1, 32'h8000, {32'hA0000004, 32'hA0000000}, 2'b00, 1'b0, 1'b0);
      send_bundle(1'b0, 32'h8008, {32'hB0000004, 32'hB0000000}, 2'b00, 1'b0, 1'b0);
      // Second bundle must enter while slot1 of the first is consumed: no bubble.
      @(negedge clk_i);
      vectors++;
      if ({out_valid_o, out_pc_o} !== {1'b1, 32'h8008}) begin
         miscompares++;
         $display("FAIL b2b_no_bubble: got valid=%b pc=%h, required 1 00008008", out_valid_o, out_pc_o);
      end
      wait_drain("b2b");
      // Consecutive redirects: the second one (slot0) decides where the next bundle starts.
      @(posedge clk_i); #1;
      branch_request_i = 1'b1; branch_pc_i = 32'h2004;
      @(posedge clk_i); #1; branch_pc_i = 32'h3000;
      @(posedge clk_i); #1; branch_request_i = 1'b0;
      exp_q.push_back({32'h9000, 32'hC0000000, 1'b0, 1'b0, 1'b0});
      exp_q.push_back({32'h9004, 32'hC0000004, 1'b0, 1'b0, 1'b0});
      send_bundle(1'b0, 32'h9000, {32'hC0000004, 32'hC0000000}, 2'b00, 1'b0, 1'b0);
      wait_drain("b2b_branch");
   endtask

   initial begin
      test_reset();
      test_dual();
      test_skip();
      test_pred();
      test_fault();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(negedge clk_i);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
